// File: rtl/midi_msg_parser.sv
// rtl/midi_msg_parser.sv - MIDI channel-voice parser driving a mono wavetable voice
module midi_msg_parser #(
    parameter logic [3:0] MIDI_CHANNEL = 4'd0,
    parameter logic       OMNI         = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_dv,
    input  logic       wtb_load_done,
    output logic [6:0] program_num,
    output logic [6:0] note_num,
    output logic [6:0] note_vel,
    output logic       gate,
    output logic       wtb_load,
    output logic [4:0] wtb_num,
    output logic       wtb_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    // Running status: message kind, data length and channel acceptance.
    logic [3:0] status_hi;
    logic       two_byte;
    logic       ignore_msg;
    logic [6:0] d1;

    // Single-entry pending load slot; a newer program change overwrites it.
    logic       pend_valid;
    logic [4:0] pend_num;

    logic       is_system;
    logic       is_chan_status;
    logic       is_data;
    logic       msg_done;
    logic [6:0] msg_d1;
    logic [6:0] msg_d2;
    logic       accept;
    logic       note_on;
    logic       note_off;
    logic       prog_chg;

    // Real-time bytes (0xF8..0xFF) fall in none of these classes, so they never disturb framing.
    assign is_system      = rx_dv && (rx_data[7:3] == 5'b11110);
    assign is_chan_status = rx_dv && rx_data[7] && (rx_data[7:4] != 4'hF);
    assign is_data        = rx_dv && !rx_data[7];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and message-completion decode.
    always_comb begin
        state_nxt = state;
        msg_done  = 1'b0;
        msg_d1    = d1;
        msg_d2    = rx_data[6:0];
        if (is_system) begin
            state_nxt = IDLE;
        end else if (is_chan_status) begin
            state_nxt = WAIT_D1;
        end else if (is_data) begin
            case (state)
                WAIT_D1: begin
                    if (two_byte) begin
                        state_nxt = WAIT_D2;
                    end else begin
                        msg_done = 1'b1;
                        msg_d1   = rx_data[6:0];
                    end
                end
                WAIT_D2: begin
                    msg_done  = 1'b1;
                    state_nxt = WAIT_D1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign accept   = msg_done && !ignore_msg;
    assign note_on  = accept && (status_hi == 4'h9) && (msg_d2 != 7'd0);
    assign note_off = accept && ((status_hi == 4'h8) || ((status_hi == 4'h9) && (msg_d2 == 7'd0)));
    assign prog_chg = accept && (status_hi == 4'hC);

    // Latch running status on channel status bytes and capture the first data byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_hi  <= 4'h0;
            two_byte   <= 1'b0;
            ignore_msg <= 1'b0;
            d1         <= 7'd0;
        end else begin
            if (is_chan_status) begin
                status_hi  <= rx_data[7:4];
                two_byte   <= !((rx_data[7:4] == 4'hC) || (rx_data[7:4] == 4'hD));
                ignore_msg <= (OMNI == 1'b0) && (rx_data[3:0] != MIDI_CHANNEL);
            end
            if (is_data && (state == WAIT_D1) && two_byte) begin
                d1 <= rx_data[6:0];
            end
        end
    end

    // Voice control outputs: last-note priority, note off only releases the sounding note.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_num    <= 7'd0;
            note_vel    <= 7'd0;
            gate        <= 1'b0;
            program_num <= 7'd0;
        end else begin
            if (note_on) begin
                note_num <= msg_d1;
                note_vel <= msg_d2;
                gate     <= 1'b1;
            end else if (note_off && (msg_d1 == note_num)) begin
                gate <= 1'b0;
            end
            if (prog_chg) begin
                program_num <= msg_d1;
            end
        end
    end

    // Wavetable load handshake; a done pulse coinciding with a program change frees the loader for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wtb_load   <= 1'b0;
            wtb_num    <= 5'd0;
            wtb_busy   <= 1'b0;
            pend_valid <= 1'b0;
            pend_num   <= 5'd0;
        end else begin
            wtb_load <= 1'b0;
            if (prog_chg) begin
                if (!wtb_busy || wtb_load_done) begin
                    wtb_load   <= 1'b1;
                    wtb_num    <= msg_d1[4:0];
                    wtb_busy   <= 1'b1;
                    pend_valid <= 1'b0;
                end else begin
                    pend_valid <= 1'b1;
                    pend_num   <= msg_d1[4:0];
                end
            end else if (wtb_load_done && wtb_busy) begin
                if (pend_valid) begin
                    wtb_load   <= 1'b1;
                    wtb_num    <= pend_num;
                    pend_valid <= 1'b0;
                end else begin
                    wtb_busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
// tb/tb_midi_msg_parser.sv - bench for midi_msg_parser with a queue-based reference model
module tb_midi_msg_parser;

    localparam logic [3:0] CH = 4'd0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_dv = 1'b0;
    logic       wtb_load_done = 1'b0;

    logic [6:0] prog_o [2];
    logic [6:0] note_o [2];
    logic [6:0] vel_o  [2];
    logic       gate_o [2];
    logic       load_o [2];
    logic [4:0] num_o  [2];
    logic       busy_o [2];

    int total = 0;
    int bad = 0;

    // Reference model: running status as an int (-1 = none), data bytes collected in a queue.
    int         m_rs;
    logic [6:0] m_q[$];
    logic [6:0] e_prog [2];
    logic [6:0] e_note [2];
    logic [6:0] e_vel  [2];
    logic       e_gate [2];
    logic       e_load [2];
    logic [4:0] e_num  [2];
    logic       e_busy [2];
    logic       e_pv   [2];
    logic [6:0] e_pend [2];

    always #5 clk = ~clk;

    midi_msg_parser #(.MIDI_CHANNEL(CH), .OMNI(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_dv(rx_dv), .wtb_load_done(wtb_load_done),
        .program_num(prog_o[0]), .note_num(note_o[0]), .note_vel(vel_o[0]), .gate(gate_o[0]),
        .wtb_load(load_o[0]), .wtb_num(num_o[0]), .wtb_busy(busy_o[0])
    );

    midi_msg_parser #(.MIDI_CHANNEL(CH), .OMNI(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_dv(rx_dv), .wtb_load_done(wtb_load_done),
        .program_num(prog_o[1]), .note_num(note_o[1]), .note_vel(vel_o[1]), .gate(gate_o[1]),
        .wtb_load(load_o[1]), .wtb_num(num_o[1]), .wtb_busy(busy_o[1])
    );

    function automatic logic [28:0] dut_out(input int k);
        return {prog_o[k], note_o[k], vel_o[k], gate_o[k], load_o[k], num_o[k], busy_o[k]};
    endfunction

    function automatic logic [28:0] exp_out(input int k);
        return {e_prog[k], e_note[k], e_vel[k], e_gate[k], e_load[k], e_num[k], e_busy[k]};
    endfunction

    task automatic model_reset();
        m_rs = -1;
        m_q.delete();
        for (int k = 0; k < 2; k++) begin
            e_prog[k] = 0; e_note[k] = 0; e_vel[k] = 0; e_gate[k] = 0;
            e_load[k] = 0; e_num[k] = 0; e_busy[k] = 0; e_pv[k] = 0; e_pend[k] = 0;
        end
    endtask

    task automatic model_update(input logic dv, input logic [7:0] d, input logic done);
        logic       fin;
        logic [6:0] md1;
        logic [6:0] md2;
        int         hi;
        int         need;
        fin = 0; md1 = 0; md2 = 0; hi = 0;
        if (dv) begin
            if (d >= 8'hF8) begin
            end else if (d >= 8'hF0) begin
                m_rs = -1;
                m_q.delete();
            end else if (d[7]) begin
                m_rs = int'(d);
                m_q.delete();
            end else if (m_rs >= 0) begin
                m_q.push_back(d[6:0]);
                need = ((m_rs / 16 == 12) || (m_rs / 16 == 13)) ? 1 : 2;
                if (m_q.size() == need) begin
                    fin = 1;
                    md1 = m_q[0];
                    md2 = (need == 2) ? m_q[1] : 7'd0;
                    m_q.delete();
                end
            end
        end
        if (fin) hi = m_rs / 16;
        for (int k = 0; k < 2; k++) begin
            logic pc;
            pc = 0;
            if (fin && (k == 1 || (m_rs % 16) == int'(CH))) begin
                if (hi == 9 && md2 != 0) begin
                    e_note[k] = md1; e_vel[k] = md2; e_gate[k] = 1;
                end else if (hi == 8 || hi == 9) begin
                    if (md1 == e_note[k]) e_gate[k] = 0;
                end else if (hi == 12) begin
                    e_prog[k] = md1;
                    pc = 1;
                end
            end
            e_load[k] = 0;
            if (pc) begin
                if (!e_busy[k] || done) begin
                    e_load[k] = 1; e_num[k] = md1[4:0]; e_busy[k] = 1; e_pv[k] = 0;
                end else begin
                    e_pv[k] = 1; e_pend[k] = md1;
                end
            end else if (done && e_busy[k]) begin
                if (e_pv[k]) begin
                    e_load[k] = 1; e_num[k] = e_pend[k][4:0]; e_pv[k] = 0;
                end else begin
                    e_busy[k] = 0;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, let the clock edge happen, then advance the model.
    task automatic step(input logic dv, input logic [7:0] d, input logic done);
        rx_dv = dv;
        rx_data = d;
        wtb_load_done = done;
        @(posedge clk);
        #1;
        model_update(dv, d, done);
        rx_dv = 0;
        wtb_load_done = 0;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic do_reset();
        rx_dv = 0;
        wtb_load_done = 0;
        #2 rst_n = 0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dut_out(k) !== 29'd0) begin
                bad++;
                $display("FAIL reset[%0d] got=%h exp=%h", k, dut_out(k), 29'd0);
            end
        end
    endtask

    task automatic test_note_on();
        send(8'h90); send(8'h3C); send(8'h64);
        total++;
        if (note_o[0] !== 7'd60 || vel_o[0] !== 7'd100 || gate_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL note_on got=%0d/%0d/%0d exp=60/100/1", note_o[0], vel_o[0], gate_o[0]);
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dut_out(k) !== exp_out(k)) begin
                bad++;
                $display("FAIL note_on_model[%0d] got=%h exp=%h", k, dut_out(k), exp_out(k));
            end
        end
    endtask

    task automatic test_running_status();
        send(8'h40); send(8'h00);
        total++;
        if (note_o[0] !== 7'd60 || gate_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL rs_other_off got=%0d/%0d exp=60/1", note_o[0], gate_o[0]);
        end
        send(8'h80); send(8'h3C); send(8'h10);
        total++;
        if (note_o[0] !== 7'd60 || gate_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL note_off got=%0d/%0d exp=60/0", note_o[0], gate_o[0]);
        end
    endtask

    task automatic test_program();
        send(8'hC0); send(8'h05);
        total++;
        if (prog_o[0] !== 7'd5 || load_o[0] !== 1'b1 || num_o[0] !== 5'd5 || busy_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL pc_load got=%0d/%0d/%0d/%0d exp=5/1/5/1", prog_o[0], load_o[0], num_o[0], busy_o[0]);
        end
        step(1'b0, 8'h00, 1'b0);
        total++;
        if (load_o[0] !== 1'b0 || busy_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL pc_pulse_width got=%0d/%0d exp=0/1", load_o[0], busy_o[0]);
        end
        send(8'hC0); send(8'h07); send(8'hC0); send(8'h09);
        total++;
        if (prog_o[0] !== 7'd9 || load_o[0] !== 1'b0 || num_o[0] !== 5'd5) begin
            bad++;
            $display("FAIL pc_pending got=%0d/%0d/%0d exp=9/0/5", prog_o[0], load_o[0], num_o[0]);
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if (load_o[0] !== 1'b1 || num_o[0] !== 5'd9 || busy_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL pc_reload got=%0d/%0d/%0d exp=1/9/1", load_o[0], num_o[0], busy_o[0]);
        end
        step(1'b0, 8'h00, 1'b0);
        total++;
        if (load_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL pc_single_reload got=%0d exp=0", load_o[0]);
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if (busy_o[0] !== 1'b0 || load_o[0] !== 1'b0 || num_o[0] !== 5'd9) begin
            bad++;
            $display("FAIL pc_done got=%0d/%0d/%0d exp=0/0/9", busy_o[0], load_o[0], num_o[0]);
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dut_out(k) !== exp_out(k)) begin
                bad++;
                $display("FAIL pc_model[%0d] got=%h exp=%h", k, dut_out(k), exp_out(k));
            end
        end
    endtask

    task automatic test_realtime_sysex();
        do_reset();
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        total++;
        if (note_o[0] !== 7'd60 || vel_o[0] !== 7'd100 || gate_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL realtime got=%0d/%0d/%0d exp=60/100/1", note_o[0], vel_o[0], gate_o[0]);
        end
        send(8'h90); send(8'h3D); send(8'hF0); send(8'h50); send(8'h41); send(8'h22);
        total++;
        if (note_o[0] !== 7'd60 || vel_o[0] !== 7'd100 || gate_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL sysex_abort got=%0d/%0d/%0d exp=60/100/1", note_o[0], vel_o[0], gate_o[0]);
        end
    endtask

    task automatic test_channel();
        do_reset();
        send(8'h93); send(8'h40); send(8'h50);
        total++;
        if (gate_o[0] !== 1'b0 || note_o[0] !== 7'd0) begin
            bad++;
            $display("FAIL chan_ignore got=%0d/%0d exp=0/0", note_o[0], gate_o[0]);
        end
        total++;
        if (gate_o[1] !== 1'b1 || note_o[1] !== 7'd64) begin
            bad++;
            $display("FAIL chan_omni got=%0d/%0d exp=64/1", note_o[1], gate_o[1]);
        end
        send(8'h90); send(8'h40); send(8'h50);
        total++;
        if (gate_o[0] !== 1'b1 || note_o[0] !== 7'd64) begin
            bad++;
            $display("FAIL chan_match got=%0d/%0d exp=64/1", note_o[0], gate_o[0]);
        end
    endtask

    task automatic test_reset_mid();
        send(8'h90); send(8'h3C);
        do_reset();
        send(8'h64);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dut_out(k) !== 29'd0) begin
                bad++;
                $display("FAIL reset_mid[%0d] got=%h exp=%h", k, dut_out(k), 29'd0);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] stat_tab [7];
        stat_tab = '{8'h80, 8'h90, 8'h90, 8'hC0, 8'hA0, 8'hB0, 8'hD0};
        for (int n = 0; n < 1500; n++) begin
            int         r;
            logic       dv;
            logic [7:0] d;
            logic       done;
            r = int'($urandom_range(0, 99));
            dv = ($urandom_range(0, 9) < 7);
            done = ($urandom_range(0, 9) == 0);
            if (r < 20)      d = stat_tab[$urandom_range(0, 6)] | 8'($urandom_range(0, 2));
            else if (r < 23) d = 8'hF0 | 8'($urandom_range(0, 7));
            else if (r < 27) d = 8'hF8 | 8'($urandom_range(0, 7));
            else if (r < 35) d = 8'h00;
            else if (r < 80) d = 8'h3C + 8'($urandom_range(0, 3));
            else             d = 8'($urandom_range(0, 127));
            step(dv, d, done);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (dut_out(k) !== exp_out(k)) begin
                    bad++;
                    $display("FAIL random[%0d] cycle=%0d got=%h exp=%h", k, n, dut_out(k), exp_out(k));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_note_on();
        test_running_status();
        test_program();
        test_realtime_sysex();
        test_channel();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
- Receives a MIDI byte stream, one byte per strobe, from the UART receiver.
- Decodes channel voice messages into the control inputs of the wavetable synthesis voice: program, note number, note velocity and gate.
- On a program change, issues a wavetable load request to the wavetable loader and tracks its completion handshake.
- Mono voice with last-note priority; sits between the MIDI UART RX and wtb_synthesis.

Parameters:
- MIDI_CHANNEL, 4'd0, channel accepted when OMNI=0 (0..15 = MIDI channels 1..16).
- OMNI, 1'b0, 1 = accept channel messages on all channels.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  received MIDI byte
- rx_dv  input  1  rx_data valid, one-cycle strobe per byte
- wtb_load_done  input  1  one-cycle pulse from the wavetable loader: load finished
- program  output  7  current program number
- note_num  output  7  currently sounding note
- note_vel  output  7  velocity of the current note
- gate  output  1  1 while a note is held
- wtb_load  output  1  one-cycle load request to the wavetable loader
- wtb_num  output  5  wavetable index for the load, equal to program[4:0]
- wtb_busy  output  1  1 from the wtb_load pulse until wtb_load_done

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, FSM in IDLE, running status cleared, no load pending.
- FSM states:
  - IDLE: no valid running status.
  - WAIT_D1: expecting the first data byte.
  - WAIT_D2: expecting the second data byte.
- Byte classes, evaluated only on cycles with rx_dv=1:
  - 0xF8..0xFF (real-time): ignored; state, running status and partial data are all unchanged.
  - 0xF0..0xF7 (system common/SysEx): clear running status, go to IDLE; data bytes are discarded until the next status byte.
  - 0x80..0xEF (channel status): latch the status byte as running status.
    - If the channel does not match and OMNI=0, mark the message ignored; its data is still framed.
    - 0xCn and 0xDn go to WAIT_D1 in 1-byte mode.
    - All other channel status bytes go to WAIT_D1 in 2-byte mode.
  - 0x00..0x7F (data):
    - IDLE: byte dropped.
    - WAIT_D1, 2-byte mode: store as d1, go to WAIT_D2.
    - WAIT_D1, 1-byte mode: message complete, return to WAIT_D1 (running status).
    - WAIT_D2: message complete, return to WAIT_D1 (running status).
  - A status byte arriving in WAIT_D2 aborts the partial message; the new status byte is processed normally.
- Message actions, applied only if the message is accepted. Outputs are registered and update on the clk edge after the completing rx_dv cycle (latency 1).
  - Note on (0x9n) with vel>0: note_num=d1, note_vel=d2, gate=1.
  - Note on with vel=0: treated exactly as note off.
  - Note off (0x8n, or 0x9n with vel=0): gate=0 only if d1==note_num. note_num and note_vel are held.
  - Program change (0xCn): program=d1. If wtb_busy=0: wtb_load=1 for one cycle, wtb_num=d1[4:0], wtb_busy=1. If wtb_busy=1: store d1 as pending; a newer program change overwrites the pending value (single-entry, newest wins).
  - 0xAn, 0xBn, 0xDn, 0xEn: framed and discarded; no output change.
- Load handshake:
  - On wtb_load_done with no pending load: wtb_busy=0.
  - On wtb_load_done with a pending load: on the next cycle issue wtb_load for the pending value and keep wtb_busy=1.
  - wtb_num holds its value between pulses.
- Simultaneous events:
  - A program change completing in the same cycle as wtb_load_done: the load is issued immediately for the newest program; no pending entry remains.
  - wtb_load_done while wtb_busy=0: ignored.
- rx_dv=0 cycles never change parser state.
- Reset mid-message: the partial message is discarded and any pending load is lost.

Test Plan:
- 0x90 0x3C 0x64 -> one cycle after the last byte: note_num=60, note_vel=100, gate=1.
- Running status 0x90 0x3C 0x64 0x40 0x00 -> note 64 is off, but it does not match note_num=60, so gate stays 1. Then 0x80 0x3C 0x10 -> gate=0, note_num stays 60.
- 0xC0 0x05 -> program=5, single wtb_load pulse with wtb_num=5, wtb_busy=1. Then 0xC0 0x07 and 0xC0 0x09 while busy, then wtb_load_done -> next cycle wtb_load pulse with wtb_num=9, and only one pulse.
- 0x90 0x3C 0xF8 0x64 (real-time byte mid-message) -> note_num=60, gate=1, identical to the first scenario. 0x90 0x3C 0xF0 0x64 -> no output change; parser in IDLE.
- MIDI_CHANNEL=0, OMNI=0: 0x93 0x40 0x50 -> no change. Then 0x90 0x40 0x50 -> note_num=64, gate=1. Same stream with OMNI=1 -> the first message is already accepted.
- Assert rst_n=0 after 0x90 0x3C, then release and send 0x64 -> byte dropped in IDLE; all outputs remain 0.
